// File: rtl/bids22_bidder_agent.sv
// BIDS22 bidder agent: initiator side of one bidder channel. Outbids maxBid by a step within a
// host limit, retracts excess when the limit drops, and captures the round result at roundOver.
module bids22_bidder_agent #(
    parameter int AMT_W       = 16,
    parameter int VAL_W       = 32,
    parameter int COOL_CYC    = 2,
    parameter int RES_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [VAL_W-1:0] cfg_limit,
    input  logic [AMT_W-1:0] cfg_step,
    input  logic             c_start,
    input  logic             ack,
    input  logic [1:0]       bid_err,
    input  logic [VAL_W-1:0] balance,
    input  logic [VAL_W-1:0] max_bid,
    input  logic             round_over,
    input  logic             win,
    output logic             bid,
    output logic             retract,
    output logic [AMT_W-1:0] bid_amt,
    output logic [VAL_W-1:0] my_total,
    output logic             res_valid,
    output logic             res_win,
    output logic [VAL_W-1:0] res_balance,
    output logic [VAL_W-1:0] res_max,
    output logic [1:0]       res_err
);
    localparam int CNT_MAX = (COOL_CYC > RES_TIMEOUT) ? COOL_CYC : RES_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [VAL_W:0] AMT_SAT = {{(VAL_W + 1 - AMT_W){1'b0}}, {AMT_W{1'b1}}};

    typedef enum logic [2:0] {IDLE, EVAL, BID, RETRACT, COOL, PARKED, WAIT_RES} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [VAL_W:0]   step_x, diff, need_x, excess_x;
    logic [VAL_W-1:0] excess;
    logic             over, leading, fits, afford, cool_done, res_expire;
    logic             cap, timeout, start_round;
    logic             bid_d, retract_d;
    logic [AMT_W-1:0] amt_d;

    // Pricing runs one bit wider than the totals so the sum/compare never wraps.
    always_comb begin
        step_x   = {{(VAL_W + 1 - AMT_W){1'b0}}, (cfg_step == '0) ? AMT_W'(1) : cfg_step};
        diff     = {1'b0, max_bid} - {1'b0, my_total} + step_x;
        need_x   = (diff > AMT_SAT) ? AMT_SAT : diff;
        excess   = my_total - cfg_limit;
        excess_x = ({1'b0, excess} > AMT_SAT) ? AMT_SAT : {1'b0, excess};
        over     = my_total > cfg_limit;
        leading  = (my_total > max_bid) || ((my_total == max_bid) && (max_bid != '0));
        fits     = ({1'b0, my_total} + need_x) <= {1'b0, cfg_limit};
        afford   = need_x <= {1'b0, balance};
        cool_done  = cnt == CNT_W'(COOL_CYC - 1);
        res_expire = cnt == CNT_W'(RES_TIMEOUT - 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (enable && c_start) state_n = EVAL;
            EVAL: begin
                if (!c_start)            state_n = WAIT_RES;
                else if (!enable)        state_n = PARKED;
                else if (over)           state_n = RETRACT;
                else if (leading)        state_n = COOL;
                else if (fits && afford) state_n = BID;
                else                     state_n = COOL;
            end
            BID: begin
                if (ack)                  state_n = COOL;
                else if (bid_err == 2'b01) state_n = WAIT_RES;
                else if (bid_err == 2'b11) state_n = PARKED;
                else                      state_n = COOL;
                if (state_n == COOL && !enable) state_n = PARKED;
            end
            RETRACT:  state_n = (bid_err == 2'b11 || !enable) ? PARKED : COOL;
            COOL: begin
                if (!c_start)       state_n = WAIT_RES;
                else if (!enable)   state_n = PARKED;
                else if (cool_done) state_n = EVAL;
            end
            PARKED:   if (!c_start) state_n = WAIT_RES;
            WAIT_RES: begin
                if (round_over)      state_n = (c_start && enable) ? EVAL : IDLE;
                else if (res_expire) state_n = IDLE;
            end
            default:  state_n = IDLE;
        endcase
        // roundOver wins over whatever the state was doing.
        if (round_over && state != WAIT_RES) state_n = (c_start && enable) ? EVAL : IDLE;
    end

    always_comb begin
        cap         = round_over;
        timeout     = (state == WAIT_RES) && !round_over && res_expire;
        start_round = (state == IDLE) && (state_n == EVAL) && !round_over;
        bid_d       = state_n == BID;
        retract_d   = state_n == RETRACT;
        amt_d       = '0;
        if (bid_d)          amt_d = need_x[AMT_W-1:0];
        else if (retract_d) amt_d = excess_x[AMT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            bid         <= 1'b0;
            retract     <= 1'b0;
            bid_amt     <= '0;
            my_total    <= '0;
            res_valid   <= 1'b0;
            res_win     <= 1'b0;
            res_balance <= '0;
            res_max     <= '0;
            res_err     <= 2'b00;
        end else begin
            bid       <= bid_d;
            retract   <= retract_d;
            bid_amt   <= amt_d;
            res_valid <= cap || timeout;

            if (state_n != state)                       cnt <= '0;
            else if (state == COOL || state == WAIT_RES) cnt <= cnt + 1'b1;

            if (cap) begin
                res_win     <= win;
                res_balance <= balance;
                res_max     <= max_bid;
            end

            if (cap || start_round)                          my_total <= '0;
            else if (state == BID && ack)                    my_total <= my_total + VAL_W'(bid_amt);
            else if (state == RETRACT && bid_err == 2'b00)   my_total <= my_total - VAL_W'(bid_amt);

            if (timeout)                                     res_err <= 2'b10;
            else if (start_round)                            res_err <= 2'b00;
            else if (state == BID && !ack && bid_err == 2'b01) res_err <= 2'b01;
            else if (((state == BID && !ack) || state == RETRACT) && bid_err == 2'b11)
                res_err <= 2'b11;
        end
    end
endmodule

// File: tb/tb_bids22_bidder_agent.sv
// Directed bench for bids22_bidder_agent: bidding, pricing out, retract, masked error,
// result timeout and asynchronous reset during a bid pulse.
module tb_bids22_bidder_agent;
    localparam int AMT_W = 16;
    localparam int VAL_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [VAL_W-1:0] cfg_limit;
    logic [AMT_W-1:0] cfg_step;
    logic             c_start;
    logic             ack;
    logic [1:0]       bid_err;
    logic [VAL_W-1:0] balance;
    logic [VAL_W-1:0] max_bid;
    logic             round_over;
    logic             win;
    logic             bid, retract, res_valid, res_win;
    logic [AMT_W-1:0] bid_amt;
    logic [VAL_W-1:0] my_total, res_balance, res_max;
    logic [1:0]       res_err;

    logic             ack_on;
    logic [1:0]       err_val;
    int               n_chk = 0;
    int               n_pass = 0;

    // Controller stand-in: same-cycle response to a request.
    assign ack     = bid & ack_on;
    assign bid_err = (bid | retract) ? err_val : 2'b00;

    always #5 clk = ~clk;

    bids22_bidder_agent #(.AMT_W(AMT_W), .VAL_W(VAL_W), .COOL_CYC(2), .RES_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .cfg_limit(cfg_limit), .cfg_step(cfg_step),
        .c_start(c_start), .ack(ack), .bid_err(bid_err), .balance(balance), .max_bid(max_bid),
        .round_over(round_over), .win(win), .bid(bid), .retract(retract), .bid_amt(bid_amt),
        .my_total(my_total), .res_valid(res_valid), .res_win(res_win), .res_balance(res_balance),
        .res_max(res_max), .res_err(res_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_req(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bid || retract) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_req(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bid || retract) n++;
        end
    endtask

    task automatic pulse_round_over(input logic w);
        round_over = 1'b1;
        win        = w;
        @(negedge clk);
        round_over = 1'b0;
    endtask

    initial begin
        bit seen;
        int n;
        reset = 1'b1; enable = 1'b1; cfg_limit = 100; cfg_step = 5; c_start = 1'b0;
        balance = 1000; max_bid = 0; round_over = 1'b0; win = 1'b0;
        ack_on = 1'b1; err_val = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_bid", bid, 0);
        chk("rst_retract", retract, 0);
        chk("rst_amt", bid_amt, 0);
        chk("rst_total", my_total, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_err", res_err, 0);
        reset = 1'b0;
        @(negedge clk);

        // Round 1: opening bid of one step, then outbid maxBid=20.
        c_start = 1'b1;
        wait_req(10, seen);
        chk("r1_bid_seen", seen, 1);
        chk("r1_bid", bid, 1);
        chk("r1_amt", bid_amt, 5);
        @(negedge clk);
        chk("r1_total", my_total, 5);
        chk("r1_bid_pulse", bid, 0);
        count_req(8, n);
        chk("r1_leading_quiet", n, 0);
        max_bid = 20;
        wait_req(10, seen);
        chk("r1_rebid_seen", seen, 1);
        chk("r1_rebid_amt", bid_amt, 20);
        @(negedge clk);
        chk("r1_total2", my_total, 25);

        // Priced out: need 8 would exceed limit 30.
        cfg_limit = 30; max_bid = 28;
        count_req(10, n);
        chk("r1_priced_out", n, 0);
        chk("r1_total3", my_total, 25);
        c_start = 1'b0;
        pulse_round_over(1'b0);
        chk("r1_res_valid", res_valid, 1);
        chk("r1_res_win", res_win, 0);
        chk("r1_res_max", res_max, 28);
        chk("r1_res_bal", res_balance, 1000);
        chk("r1_total_clr", my_total, 0);
        @(negedge clk);
        chk("r1_res_pulse", res_valid, 0);

        // Round 2: bid 25, then the limit drops to 10 -> retract 15.
        cfg_limit = 100; max_bid = 20; c_start = 1'b1;
        wait_req(10, seen);
        chk("r2_bid_amt", bid_amt, 25);
        @(negedge clk);
        chk("r2_total", my_total, 25);
        cfg_limit = 10;
        wait_req(10, seen);
        chk("r2_retract", retract, 1);
        chk("r2_retract_nobid", bid, 0);
        chk("r2_retract_amt", bid_amt, 15);
        @(negedge clk);
        chk("r2_total_after", my_total, 10);
        chk("r2_amt_idle", bid_amt, 0);
        count_req(8, n);
        chk("r2_quiet", n, 0);
        c_start = 1'b0; balance = 1234;
        repeat (2) @(negedge clk);
        pulse_round_over(1'b1);
        chk("r2_res_valid", res_valid, 1);
        chk("r2_res_win", res_win, 1);
        chk("r2_res_bal", res_balance, 1234);
        chk("r2_res_max", res_max, 20);
        chk("r2_res_err", res_err, 0);

        // Round 3: masked on first bid -> parked until the round ends.
        cfg_limit = 100; max_bid = 0; ack_on = 1'b0; err_val = 2'b11;
        @(negedge clk);
        c_start = 1'b1;
        wait_req(10, seen);
        chk("r3_bid_seen", seen, 1);
        @(negedge clk);
        chk("r3_res_err", res_err, 3);
        count_req(15, n);
        chk("r3_parked", n, 0);
        c_start = 1'b0;
        repeat (2) @(negedge clk);
        pulse_round_over(1'b0);
        chk("r3_res_valid", res_valid, 1);
        chk("r3_res_err_kept", res_err, 3);
        ack_on = 1'b1; err_val = 2'b00;

        // Round 4: c_start falls and round_over never comes.
        @(negedge clk);
        c_start = 1'b1;
        wait_req(10, seen);
        chk("r4_bid_amt", bid_amt, 5);
        repeat (4) @(negedge clk);
        c_start = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (res_valid) begin
                n = i;
                break;
            end
        end
        chk("r4_timeout_cycles", n, 9);
        chk("r4_res_err", res_err, 2);
        chk("r4_res_max_kept", res_max, 0);

        // Round 5: reset while bid is high drops it without a clock edge.
        @(negedge clk);
        c_start = 1'b1;
        wait_req(10, seen);
        chk("r5_bid_high", bid, 1);
        #1 reset = 1'b1;
        #1;
        chk("r5_async_bid", bid, 0);
        chk("r5_async_amt", bid_amt, 0);
        chk("r5_async_err", res_err, 0);
        @(negedge clk);
        c_start = 1'b0;
        reset = 1'b0;
        count_req(4, n);
        chk("r5_idle_quiet", n, 0);
        chk("r5_total", my_total, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
